// File: rtl/scsi_byte_packer_if.sv
// Longword hand-off between the SCSI byte packer and the bus-master write logic.
// The producer drives data, lane mask and valid; the consumer answers with ready.
interface scsi_byte_packer_if;
  logic [31:0] LW_DATA;
  logic [3:0]  LW_MASK;
  logic        LW_VALID;
  logic        LW_READY;

  modport master (output LW_DATA, output LW_MASK, output LW_VALID, input LW_READY);
  modport slave  (input LW_DATA, input LW_MASK, input LW_VALID, output LW_READY);
endinterface

// File: rtl/scsi_byte_packer.sv
// WD33C93A DMA read-side byte handshake: strobes PD_PORT bytes in and packs them
// big-endian into longwords for the memory write master, with partial-word flush.
module scsi_byte_packer #(
  parameter int IOR_CYCLES     = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic               SCLK,
  input  logic               _RST,
  input  logic               DMA_EN,
  input  logic               DMADIR,
  input  logic               FLUSH,
  input  logic               _DREQ,
  input  logic [7:0]         PD_IN,
  output logic               _DACK,
  output logic               _IOR,
  output logic               FLUSH_DONE,
  output logic               BUSY,
  scsi_byte_packer_if.master lw
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STROBE  = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  logic [1:0]  state;
  logic [7:0]  tmr;
  logic [1:0]  cnt;
  logic [31:0] byte_buf;
  logic        flush_pending;
  logic        dreq_meta;
  logic        dreq_sync;
  logic        dreq_s;
  logic        start;
  logic        strobe_end;
  logic        accept;
  logic        word_load;
  logic        flush_load;
  logic        flush_finish;
  logic [3:0]  part_mask;

  assign dreq_s     = ~dreq_sync;
  assign accept     = lw.LW_VALID & lw.LW_READY;
  // The 4th byte may only start once the output register has drained.
  assign start      = (state == IDLE) & DMA_EN & DMADIR & dreq_s & ~flush_pending
                      & ~((cnt == 2'd3) & lw.LW_VALID);
  assign strobe_end = (state == STROBE) & (tmr == 8'(IOR_CYCLES - 1));
  assign word_load  = strobe_end & (cnt == 2'd3);

  // A flush waits for any strobe in flight so the byte count is final.
  assign flush_load   = flush_pending & (state != STROBE) & (cnt != 2'd0) & ~lw.LW_VALID;
  assign flush_finish = flush_pending & (state != STROBE) & (cnt == 2'd0)
                        & (~lw.LW_VALID | accept);

  assign BUSY = (state != IDLE) | (cnt != 2'd0) | lw.LW_VALID;

  always_comb begin
    part_mask = 4'b0000;
    case (cnt)
      2'd1:    part_mask = 4'b1000;
      2'd2:    part_mask = 4'b1100;
      2'd3:    part_mask = 4'b1110;
      default: part_mask = 4'b0000;
    endcase
  end

  // _DREQ is asynchronous to SCLK; idle level is high (no request).
  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      dreq_meta <= 1'b1;
      dreq_sync <= 1'b1;
    end else begin
      dreq_meta <= _DREQ;
      dreq_sync <= dreq_meta;
    end
  end

  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      state <= IDLE;
      tmr   <= '0;
      _DACK <= 1'b1;
      _IOR  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= STROBE;
            tmr   <= '0;
            _DACK <= 1'b0;
            _IOR  <= 1'b0;
          end
        end
        STROBE: begin
          if (strobe_end) begin
            state <= RECOVER;
            tmr   <= '0;
            _DACK <= 1'b1;
            _IOR  <= 1'b1;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        RECOVER: begin
          if (tmr == 8'(RECOVER_CYCLES - 1)) begin
            state <= IDLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          tmr   <= '0;
          _DACK <= 1'b1;
          _IOR  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      cnt         <= '0;
      byte_buf    <= '0;
      lw.LW_DATA  <= '0;
      lw.LW_MASK  <= '0;
      lw.LW_VALID <= 1'b0;
    end else begin
      if (word_load) begin
        lw.LW_DATA  <= {byte_buf[31:8], PD_IN};
        lw.LW_MASK  <= 4'hF;
        lw.LW_VALID <= 1'b1;
      end else if (flush_load) begin
        lw.LW_DATA  <= byte_buf;
        lw.LW_MASK  <= part_mask;
        lw.LW_VALID <= 1'b1;
      end else if (accept) begin
        lw.LW_VALID <= 1'b0;
      end

      // Clearing the buffer on every load keeps unused lanes of a partial word zero.
      if (word_load || flush_load) begin
        cnt      <= '0;
        byte_buf <= '0;
      end else if (strobe_end) begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd0:    byte_buf[31:24] <= PD_IN;
          2'd1:    byte_buf[23:16] <= PD_IN;
          default: byte_buf[15:8]  <= PD_IN;
        endcase
      end
    end
  end

  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      flush_pending <= 1'b0;
      FLUSH_DONE    <= 1'b0;
    end else begin
      FLUSH_DONE <= flush_finish;
      if (flush_finish) begin
        flush_pending <= 1'b0;
      end else if (FLUSH) begin
        flush_pending <= 1'b1;
      end
    end
  end

endmodule
